alu_cmd_driver: RTL and testbench
=================================

ALU_CMD_DRIVER -- requirements
Module: alu_cmd_driver

Interface
REQ-001 Parameter DEPTH, default 4, meaning command FIFO depth in entries; power of two, 2..16.
REQ-002 Parameter ALU_LATENCY, default 1, meaning clock edges between the ALU sampling a/b/op_code and result/carry_out being stable; range 0..7.
REQ-003 Port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, meaning reset; asynchronous, active-high.
REQ-005 Port cmd_valid, input, 1, meaning a command is offered.
REQ-006 Port cmd_ready, output, 1, meaning the block accepts a command this cycle.
REQ-007 Port cmd_a, input, 8, meaning operand A.
REQ-008 Port cmd_b, input, 8, meaning operand B.
REQ-009 Port cmd_op, input, 2, meaning the opcode.
REQ-010 Port a, output, 8, meaning operand A driven to the ALU.
REQ-011 Port b, output, 8, meaning operand B driven to the ALU.
REQ-012 Port op_code, output, 2, meaning the opcode driven to the ALU.
REQ-013 Port result, input, 8, meaning the ALU result.
REQ-014 Port carry_out, input, 1, meaning the ALU carry.
REQ-015 Port rsp_valid, output, 1, meaning a captured response is held.
REQ-016 Port rsp_ready, input, 1, meaning the consumer accepts the response.
REQ-017 Port rsp_result, output, 8, meaning the captured result.
REQ-018 Port rsp_carry, output, 1, meaning the captured carry.
REQ-019 Port busy, output, 1, meaning the state is not IDLE or the FIFO is not empty.
REQ-020 Port op_count, output, 16, meaning completed responses, wrapping modulo 2^16.

Function
REQ-021 Command transfer: occurs on an edge with cmd_valid=1 and cmd_ready=1; cmd_ready=1 exactly when the FIFO is not full.
- cmd_ready depends on FIFO fill only, never on cmd_valid.
REQ-022 FIFO behaviour:
- order is first-in first-out;
- pointers wrap modulo DEPTH;
- a push and a pop on the same edge leave the occupancy unchanged;
- cmd_ready is low when full, so no push can occur while full.
REQ-023 State machine: states IDLE, WAIT, RESP; only one operation is outstanding at a time.
REQ-024 IDLE with FIFO non-empty: on the next edge, pop the head, load a/b/op_code from it, load the wait counter with ALU_LATENCY, and go to WAIT.
- A command pushed into an empty FIFO is issued no earlier than the edge after its transfer.
REQ-025 WAIT: decrement the counter each edge.
- On the edge where the counter is 0, sample result and carry_out into rsp_result and rsp_carry, set rsp_valid=1, and go to RESP.
- Sampling therefore occurs ALU_LATENCY+1 edges after a/b/op_code were updated.
REQ-026 a, b and op_code SHALL hold their last issued values in all states; they change only on an issue edge.
REQ-027 RESP: hold rsp_valid, rsp_result and rsp_carry stable until an edge with rsp_ready=1.
- On that edge, increment op_count.
- If the FIFO is non-empty, issue the next command on the same edge (as in REQ-024) and go to WAIT.
- Otherwise clear rsp_valid and go to IDLE.
REQ-028 Back-to-back throughput: with rsp_ready held at 1, one response every ALU_LATENCY+2 cycles.
REQ-029 rsp_valid SHALL stay high continuously across a RESP-to-WAIT back-to-back transition only until the accepting edge; it is low during WAIT.
REQ-030 Commands continue to be accepted in WAIT and RESP while the FIFO is not full.
REQ-031 op_count wraps from 0xFFFF to 0x0000 without affecting any other state.

Reset
REQ-032 Asserting rst SHALL, immediately and regardless of clk:
- set the state to IDLE;
- empty the FIFO;
- clear the wait counter;
- drive a=0, b=0, op_code=0;
- drive rsp_valid=0, rsp_result=0, rsp_carry=0;
- drive op_count=0 and busy=0.
REQ-033 cmd_ready SHALL be 0 while rst=1 and 1 from the first cycle after deassertion.
REQ-034 Reset during WAIT or RESP SHALL discard the in-flight operation and all queued commands; no response is produced for them.

Verification
REQ-035 Bench model: registered ALU with op 00=add, carry = bit 8 of a+b; ALU_LATENCY=1.
- Push {a=0xF0, b=0x20, op=00}.
- Required: a/b/op_code update 1 edge after the transfer; rsp_valid rises 2 edges later with rsp_result=0x10, rsp_carry=1; op_count=1 after rsp_ready.
REQ-036 Hold rsp_ready=0 for 5 cycles, then assert it.
- Required: rsp fields stay stable for those 5 cycles; a/b/op_code do not change; exactly one op_count increment.
REQ-037 With rsp_ready=0, push DEPTH+1 commands back-to-back.
- Required: cmd_ready falls after DEPTH accepted transfers while one command is in WAIT/RESP.
- Required: all commands complete in order once rsp_ready=1.
- Required: responses are spaced 3 cycles apart.
REQ-038 Assert rst asynchronously mid-WAIT with 3 commands queued.
- Required: all outputs at their reset values at once.
- Required: no rsp_valid afterwards without new commands; busy=0.
REQ-039 Force op_count=0xFFFE, then complete 3 operations.
- Required: op_count sequence 0xFFFF, 0x0000, 0x0001.
REQ-040 Rerun REQ-035 with ALU_LATENCY=0 and a combinational ALU model.
- Required: rsp_valid rises 1 edge after the issue edge with the correct result.

Source files
------------

// File: rtl/alu_cmd_driver_if.sv
// rtl/alu_cmd_driver_if.sv - command, ALU and response signals of alu_cmd_driver
interface alu_cmd_driver_if;
  // command stream into the block
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic [1:0]  cmd_op;
  // operands out to the ALU and its answer back
  logic [7:0]  a;
  logic [7:0]  b;
  logic [1:0]  op_code;
  logic [7:0]  result;
  logic        carry_out;
  // captured response stream
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_result;
  logic        rsp_carry;
  // status
  logic        busy;
  logic [15:0] op_count;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, result, carry_out, rsp_ready,
    output cmd_ready, a, b, op_code, rsp_valid, rsp_result, rsp_carry, busy, op_count
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, result, carry_out, rsp_ready,
    input  cmd_ready, a, b, op_code, rsp_valid, rsp_result, rsp_carry, busy, op_count
  );
endinterface

// File: rtl/alu_cmd_driver.sv
// rtl/alu_cmd_driver.sv - command FIFO feeding an ALU one operation at a time, with response capture
module alu_cmd_driver #(
  parameter int DEPTH       = 4,
  parameter int ALU_LATENCY = 1
) (
  input  logic            clk,
  input  logic            rst,
  alu_cmd_driver_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;

  // FIFO entry layout: {op[1:0], a[7:0], b[7:0]}
  logic [17:0]       mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  fill_q, fill_d;

  logic [2:0]        wait_q, wait_d;
  logic [7:0]        a_q, a_d;
  logic [7:0]        b_q, b_d;
  logic [1:0]        op_q, op_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [7:0]        rsp_result_q, rsp_result_d;
  logic              rsp_carry_q, rsp_carry_d;
  logic [15:0]       op_count_q, op_count_d;

  logic              fifo_empty;
  logic              fifo_full;
  logic              push;
  logic              issue;
  logic              capture;
  logic              complete;
  logic [17:0]       head;

  assign fifo_empty    = (fill_q == '0);
  assign fifo_full     = (fill_q == CNT_W'(DEPTH));
  assign head          = mem_q[rd_ptr_q];
  // Readiness is a pure function of fill; held low while reset is applied.
  assign bus.cmd_ready = ~fifo_full & ~rst;
  assign push          = bus.cmd_valid & bus.cmd_ready;

  assign bus.a          = a_q;
  assign bus.b          = b_q;
  assign bus.op_code    = op_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_carry  = rsp_carry_q;
  assign bus.op_count   = op_count_q;
  assign bus.busy       = (state_q != S_IDLE) | ~fifo_empty;

  // FIFO storage write; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bus.cmd_op, bus.cmd_a, bus.cmd_b};
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: a single operation is in flight between issue and response acceptance
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (!fifo_empty) state_d = S_WAIT;
      S_WAIT: if (wait_q == 3'd0) state_d = S_RESP;
      S_RESP: if (bus.rsp_ready) state_d = fifo_empty ? S_IDLE : S_WAIT;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: issue pops the head, capture samples the ALU, complete retires the response
  always_comb begin
    issue    = 1'b0;
    capture  = 1'b0;
    complete = 1'b0;
    case (state_q)
      S_IDLE: issue = ~fifo_empty;
      S_WAIT: capture = (wait_q == 3'd0);
      S_RESP: begin
        complete = bus.rsp_ready;
        issue    = bus.rsp_ready & ~fifo_empty;
      end
      default: ;
    endcase
  end

  // Datapath next-state: FIFO pointers, wait counter, ALU operands, response and counter
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fill_d       = fill_q;
    wait_d       = wait_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    op_count_d   = op_count_q;

    if (push)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (issue) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, issue})
      2'b10:   fill_d = fill_q + CNT_W'(1);
      2'b01:   fill_d = fill_q - CNT_W'(1);
      default: ;
    endcase

    // Operands only move on an issue edge so the ALU sees stable inputs otherwise.
    if (issue) begin
      op_d   = head[17:16];
      a_d    = head[15:8];
      b_d    = head[7:0];
      wait_d = 3'(ALU_LATENCY);
    end else if ((state_q == S_WAIT) && (wait_q != 3'd0)) begin
      wait_d = wait_q - 3'd1;
    end

    // Accepting a response always drops valid; a back-to-back issue re-raises it only on capture.
    if (capture) begin
      rsp_valid_d  = 1'b1;
      rsp_result_d = bus.result;
      rsp_carry_d  = bus.carry_out;
    end else if (complete) begin
      rsp_valid_d  = 1'b0;
    end

    if (complete) op_count_d = op_count_q + 16'd1;
  end

  // Datapath registers with asynchronous reset to an empty, idle block
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fill_q       <= '0;
      wait_q       <= 3'd0;
      a_q          <= 8'd0;
      b_q          <= 8'd0;
      op_q         <= 2'd0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= 8'd0;
      rsp_carry_q  <= 1'b0;
      op_count_q   <= 16'd0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fill_q       <= fill_d;
      wait_q       <= wait_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
      op_count_q   <= op_count_d;
    end
  end
endmodule

// File: tb/tb_alu_cmd_driver.sv
// tb/tb_alu_cmd_driver.sv - randomized and directed bench for alu_cmd_driver
module tb_alu_cmd_driver;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_cmd_driver_if bus0 ();
  alu_cmd_driver_if bus1 ();

  alu_cmd_driver #(.DEPTH(DEPTH), .ALU_LATENCY(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  alu_cmd_driver #(.DEPTH(DEPTH), .ALU_LATENCY(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  // ALU behaviour: 00 add, 01 subtract (carry = borrow), 10 and, 11 xor
  function automatic logic [8:0] alu_f(input logic [7:0] x, input logic [7:0] y, input logic [1:0] op);
    case (op)
      2'd0:    return {1'b0, x} + {1'b0, y};
      2'd1:    return {1'b0, x} - {1'b0, y};
      2'd2:    return {1'b0, x & y};
      default: return {1'b0, x ^ y};
    endcase
  endfunction

  // registered ALU (latency 1) for dut0, combinational ALU for dut1
  always @(posedge clk) {bus0.carry_out, bus0.result} <= alu_f(bus0.a, bus0.b, bus0.op_code);
  always_comb {bus1.carry_out, bus1.result} = alu_f(bus1.a, bus1.b, bus1.op_code);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // reference model: expected responses in order, and the completed-operation count
  logic [8:0]  exp_q [$];
  logic [15:0] exp_cnt = 16'd0;
  logic        hold_prev = 1'b0;
  logic [8:0]  held_val;
  logic        took;
  int          last_v;
  int          gaps;

  // one clock of dut0 with the given inputs; model tracks transfers and retired responses
  task automatic cyc(input logic cv, input logic [7:0] ca, input logic [7:0] cb,
                     input logic [1:0] cop, input logic rr, output logic acc);
    logic [8:0] r;
    bus0.cmd_valid = cv;
    bus0.cmd_a     = ca;
    bus0.cmd_b     = cb;
    bus0.cmd_op    = cop;
    bus0.rsp_ready = rr;
    if (bus0.rsp_valid && rr) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        r = exp_q.pop_front();
        check("rsp_result", {24'd0, bus0.rsp_result}, {24'd0, r[7:0]});
        check("rsp_carry", {31'd0, bus0.rsp_carry}, {31'd0, r[8]});
      end
      exp_cnt = exp_cnt + 16'd1;
    end
    acc = cv && bus0.cmd_ready;
    if (acc) exp_q.push_back(alu_f(ca, cb, cop));
    hold_prev = bus0.rsp_valid && !rr;
    held_val  = {bus0.rsp_carry, bus0.rsp_result};
    step();
    check("op_count", {16'd0, bus0.op_count}, {16'd0, exp_cnt});
    check("busy", {31'd0, bus0.busy}, {31'd0, exp_q.size() != 0});
    if (hold_prev) begin
      check("rsp_hold_valid", {31'd0, bus0.rsp_valid}, 32'd1);
      check("rsp_hold_data", {23'd0, bus0.rsp_carry, bus0.rsp_result}, {23'd0, held_val});
    end
  endtask

  task automatic drain(input string tag);
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) cyc(1'b0, 8'd0, 8'd0, 2'd0, 1'b1, took);
    check(tag, exp_q.size(), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus0.cmd_valid = 1'b0; bus0.cmd_a = 8'd0; bus0.cmd_b = 8'd0; bus0.cmd_op = 2'd0; bus0.rsp_ready = 1'b0;
    bus1.cmd_valid = 1'b0; bus1.cmd_a = 8'd0; bus1.cmd_b = 8'd0; bus1.cmd_op = 2'd0; bus1.rsp_ready = 1'b0;

    // reset state
    rst = 1'b1;
    #1;
    check("rst_cmd_ready", {31'd0, bus0.cmd_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, bus0.rsp_valid}, 32'd0);
    check("rst_busy", {31'd0, bus0.busy}, 32'd0);
    check("rst_op_count", {16'd0, bus0.op_count}, 32'd0);
    check("rst_abop", {14'd0, bus0.op_code, bus0.a, bus0.b}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_release_ready", {31'd0, bus0.cmd_ready}, 32'd1);

    // single add 0xF0 + 0x20 and its timing
    cyc(1'b1, 8'hF0, 8'h20, 2'd0, 1'b0, took);
    check("t35_accept", {31'd0, took}, 32'd1);
    check("t35_a_before_issue", {24'd0, bus0.a}, 32'd0);
    cyc(1'b0, 8'd0, 8'd0, 2'd0, 1'b0, took);
    check("t35_issue", {14'd0, bus0.op_code, bus0.a, bus0.b}, {14'd0, 2'd0, 8'hF0, 8'h20});
    check("t35_valid_wait1", {31'd0, bus0.rsp_valid}, 32'd0);
    cyc(1'b0, 8'd0, 8'd0, 2'd0, 1'b0, took);
    check("t35_valid_wait2", {31'd0, bus0.rsp_valid}, 32'd0);
    cyc(1'b0, 8'd0, 8'd0, 2'd0, 1'b0, took);
    check("t35_valid", {31'd0, bus0.rsp_valid}, 32'd1);
    check("t35_result", {24'd0, bus0.rsp_result}, 32'h10);
    check("t35_carry", {31'd0, bus0.rsp_carry}, 32'd1);

    // back-pressure for 5 cycles, then accept
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 8'd0, 8'd0, 2'd0, 1'b0, took);
      check("t36_result_stable", {23'd0, bus0.rsp_carry, bus0.rsp_result}, {23'd0, 1'b1, 8'h10});
      check("t36_abop_stable", {14'd0, bus0.op_code, bus0.a, bus0.b}, {14'd0, 2'd0, 8'hF0, 8'h20});
      check("t36_count_hold", {16'd0, bus0.op_count}, 32'd0);
    end
    cyc(1'b0, 8'd0, 8'd0, 2'd0, 1'b1, took);
    check("t36_count_one", {16'd0, bus0.op_count}, 32'd1);
    check("t36_valid_drop", {31'd0, bus0.rsp_valid}, 32'd0);
    cyc(1'b0, 8'd0, 8'd0, 2'd0, 1'b1, took);
    check("t36_count_still_one", {16'd0, bus0.op_count}, 32'd1);

    // fill: DEPTH+1 transfers while stalled, then drain at full rate
    for (int i = 0; i <= DEPTH; i++) begin
      cyc(1'b1, 8'($urandom), 8'($urandom), 2'($urandom), 1'b0, took);
      check("t37_accept", {31'd0, took}, 32'd1);
    end
    check("t37_full", {31'd0, bus0.cmd_ready}, 32'd0);
    cyc(1'b1, 8'h55, 8'hAA, 2'd3, 1'b0, took);
    check("t37_refused", {31'd0, took}, 32'd0);
    last_v = -1;
    gaps = 0;
    for (int c = 0; c < 60 && exp_q.size() != 0; c++) begin
      if (bus0.rsp_valid) begin
        if (last_v >= 0) begin
          check("t37_spacing", c - last_v, 32'd3);
          gaps++;
        end
        last_v = c;
      end
      cyc(1'b0, 8'd0, 8'd0, 2'd0, 1'b1, took);
    end
    check("t37_drain", exp_q.size(), 32'd0);
    check("t37_gaps", gaps, DEPTH);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 2'($urandom),
          1'($urandom_range(0, 3) != 0), took);
    end
    drain("rand_drain");

    // asynchronous reset in WAIT with three commands queued
    for (int i = 0; i <= DEPTH; i++) cyc(1'b1, 8'($urandom), 8'($urandom), 2'($urandom), 1'b0, took);
    for (int c = 0; c < 10 && !bus0.rsp_valid; c++) cyc(1'b0, 8'd0, 8'd0, 2'd0, 1'b0, took);
    check("t38_first_rsp", {31'd0, bus0.rsp_valid}, 32'd1);
    cyc(1'b0, 8'd0, 8'd0, 2'd0, 1'b1, took);
    check("t38_in_wait", {31'd0, bus0.rsp_valid}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check("t38_cmd_ready", {31'd0, bus0.cmd_ready}, 32'd0);
    check("t38_rsp", {22'd0, bus0.rsp_valid, bus0.rsp_carry, bus0.rsp_result}, 32'd0);
    check("t38_abop", {14'd0, bus0.op_code, bus0.a, bus0.b}, 32'd0);
    check("t38_count_busy", {15'd0, bus0.busy, bus0.op_count}, 32'd0);
    exp_q.delete();
    exp_cnt = 16'd0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t38_ready_after", {31'd0, bus0.cmd_ready}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 8'd0, 8'd0, 2'd0, 1'b1, took);
      check("t38_no_rsp", {31'd0, bus0.rsp_valid}, 32'd0);
    end

    // op_count wrap
    force dut0.op_count_q = 16'hFFFE;
    step();
    release dut0.op_count_q;
    exp_cnt = 16'hFFFE;
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 8'($urandom), 8'($urandom), 2'($urandom), 1'b1, took);
      drain("t39_drain");
      check("t39_seq", {16'd0, bus0.op_count}, (k == 0) ? 32'hFFFF : ((k == 1) ? 32'h0 : 32'h1));
    end

    // zero-latency instance with combinational ALU
    bus1.cmd_valid = 1'b1; bus1.cmd_a = 8'hF0; bus1.cmd_b = 8'h20; bus1.cmd_op = 2'd0;
    step();
    bus1.cmd_valid = 1'b0;
    check("t40_a_before_issue", {24'd0, bus1.a}, 32'd0);
    step();
    check("t40_issue", {14'd0, bus1.op_code, bus1.a, bus1.b}, {14'd0, 2'd0, 8'hF0, 8'h20});
    check("t40_valid_low", {31'd0, bus1.rsp_valid}, 32'd0);
    step();
    check("t40_valid", {31'd0, bus1.rsp_valid}, 32'd1);
    check("t40_result", {23'd0, bus1.rsp_carry, bus1.rsp_result}, {23'd0, 1'b1, 8'h10});
    bus1.rsp_ready = 1'b1;
    step();
    bus1.rsp_ready = 1'b0;
    check("t40_count", {16'd0, bus1.op_count}, 32'd1);
    check("t40_idle", {30'd0, bus1.rsp_valid, bus1.busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
